// File: rtl/nibble_demux_packer.sv
// nibble_demux_packer: scatters a 4-bit stream into lanes 0..15 of a 64-bit word, handed off on valid/ready.
// Define DEMUX_FLUSH_EN to add the flush port, which emits a partially filled word.
module nibble_demux_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
`ifdef DEMUX_FLUSH_EN
    input  logic        flush,
`endif
    output logic [63:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_lanes
);
    typedef enum logic {FILL, HOLD} state_t;
    state_t      state_q, state_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [63:0] stage_q, stage_d;
    logic [4:0]  lanes_q, lanes_d;
    logic        acc, take, close;
    assign acc  = in_valid && state_q == FILL;
    assign take = out_ready && state_q == HOLD;
`ifdef DEMUX_FLUSH_EN
    assign close = (acc && ptr_q == 4'd15) || (flush && state_q == FILL && (acc || ptr_q != 4'd0));
`else
    assign close = acc && ptr_q == 4'd15;
`endif
    // ptr parks at 15 on a full word; only the handshake returns it to 0
    always_comb begin
        state_d = close ? HOLD : take ? FILL : state_q;
        ptr_d   = take ? 4'd0 : (acc && ptr_q != 4'd15) ? ptr_q + 4'd1 : ptr_q;
        stage_d = take ? 64'h0 : acc ? stage_q | (64'(in_data) << {ptr_q, 2'b00}) : stage_q;
        lanes_d = take ? 5'd0 : close ? {1'b0, ptr_q} + {4'd0, acc} : lanes_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            ptr_q   <= 4'd0;
            stage_q <= 64'h0;
            lanes_q <= 5'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            stage_q <= stage_d;
            lanes_q <= lanes_d;
        end
    end
    assign in_ready  = state_q == FILL;
    assign out_valid = state_q == HOLD;
    assign out_data  = stage_q;
    assign out_lanes = lanes_q;
endmodule
